// File: rtl/vsa16_dmem_pkg.sv
// -----------------------------------------------------------------------------
// vsa16_dmem_pkg
// Shared constants and the address decoder for the VSA16 data-memory stage.
//   MMIO_FIFO_PORT / MMIO_STATUS : the two live MMIO word addresses
//   MMIO_BIT                     : address bit selecting the MMIO window
//   ST_MISALIGN / ST_OVERFLOW    : bit positions inside the STATUS word
// -----------------------------------------------------------------------------
package vsa16_dmem_pkg;

    localparam logic [15:0] MMIO_FIFO_PORT = 16'h8000;
    localparam logic [15:0] MMIO_STATUS    = 16'h8002;
    localparam int          MMIO_BIT       = 15;

    localparam int ST_MISALIGN = 0;
    localparam int ST_OVERFLOW = 1;

    typedef enum logic [1:0] {
        REGION_RAM,
        REGION_FIFO,
        REGION_STATUS,
        REGION_NONE
    } region_e;

    // MMIO registers are matched on the full address, so an odd address
    // inside the window is treated as an unmapped location.
    function automatic region_e decode_region(input logic [15:0] addr);
        if (!addr[MMIO_BIT])               return REGION_RAM;
        else if (addr == MMIO_FIFO_PORT)   return REGION_FIFO;
        else if (addr == MMIO_STATUS)      return REGION_STATUS;
        else                               return REGION_NONE;
    endfunction

endpackage

// File: rtl/vsa16_store_fifo.sv
// -----------------------------------------------------------------------------
// vsa16_store_fifo
// Circular store FIFO drained by an external consumer over valid/ready.
//   clock, rst  : clock, synchronous active-high reset
//   push        : enqueue push_data this cycle
//   push_data   : 16-bit entry to enqueue
//   pop_ready   : consumer takes the head when valid is also high
//   valid       : FIFO non-empty (registered state only)
//   head        : entry at the read pointer (stale entry when empty)
//   count       : occupancy, 0..2^FD_LOG2
//   full        : count == depth
//   drop        : a push was refused this cycle (full, no concurrent pop)
// -----------------------------------------------------------------------------
module vsa16_store_fifo #(
    parameter int FD_LOG2 = 2
) (
    input  logic               clock,
    input  logic               rst,
    input  logic               push,
    input  logic [15:0]        push_data,
    input  logic               pop_ready,
    output logic               valid,
    output logic [15:0]        head,
    output logic [FD_LOG2:0]   count,
    output logic               full,
    output logic               drop
);

    localparam int DEPTH = 1 << FD_LOG2;
    localparam logic [FD_LOG2:0] DEPTH_CNT = DEPTH[FD_LOG2:0];

    logic [15:0]        store [DEPTH];
    logic [FD_LOG2-1:0] rd_ptr;
    logic [FD_LOG2-1:0] wr_ptr;
    logic               pop;
    logic               do_push;

    assign valid = (count != '0);
    assign full  = (count == DEPTH_CNT);
    assign head  = store[rd_ptr];

    // A pop in the same cycle frees the slot, so a push into a full FIFO
    // is only refused when the consumer is not taking the head.
    assign pop     = valid && pop_ready;
    assign do_push = push && (!full || pop);
    assign drop    = push && full && !pop;

    // NOTE: Sequential state uses non-blocking assignments so every register
    // samples the pre-edge values, independent of statement order.
    always_ff @(posedge clock) begin
        if (rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (pop)
                rd_ptr <= rd_ptr + 1'b1;
            if (do_push)
                wr_ptr <= wr_ptr + 1'b1;
            if (do_push && !pop)
                count <= count + 1'b1;
            else if (pop && !do_push)
                count <= count - 1'b1;
        end
    end

    // NOTE: Entry storage is deliberately not reset; count gates visibility,
    // so stale contents are never observed as valid data.
    always_ff @(posedge clock) begin
        if (do_push)
            store[wr_ptr] <= push_data;
    end

endmodule

// File: rtl/vsa16_dmem.sv
// -----------------------------------------------------------------------------
// vsa16_dmem
// Data-memory stage for the VSA16 core: word-organised scratchpad RAM with
// combinational read / synchronous write, plus an MMIO window holding a
// store FIFO and sticky error flags. Every access completes in one cycle.
//   clock, rst   : clock, synchronous active-high reset
//   addr         : byte address from the core
//   wdata        : store data from the core
//   wr           : store strobe (one cycle per store)
//   rdata        : combinational load data for the current addr
//   out_valid    : store FIFO non-empty
//   out_data     : store FIFO head entry
//   out_ready    : consumer accepts the head when out_valid is high
//   err_misalign : sticky, a store used an odd address
//   err_overflow : sticky, a FIFO push was dropped because it was full
// -----------------------------------------------------------------------------
module vsa16_dmem
    import vsa16_dmem_pkg::*;
#(
    parameter int AW      = 4,
    parameter int FD_LOG2 = 2
) (
    input  logic        clock,
    input  logic        rst,
    input  logic [15:0] addr,
    input  logic [15:0] wdata,
    input  logic        wr,
    output logic [15:0] rdata,
    output logic        out_valid,
    output logic [15:0] out_data,
    input  logic        out_ready,
    output logic        err_misalign,
    output logic        err_overflow
);

    localparam int WORDS = 1 << AW;

    logic [15:0]      ram [WORDS];
    logic [AW-1:0]    word_idx;
    region_e          region;
    logic             aligned_wr;
    logic             fifo_push;
    logic             fifo_drop;
    logic             fifo_full;
    logic [FD_LOG2:0] fifo_count;

    // Upper RAM-region bits are ignored, so the RAM aliases modulo its depth.
    assign word_idx   = addr[AW:1];
    assign region     = decode_region(addr);
    assign aligned_wr = wr && !addr[0];
    assign fifo_push  = aligned_wr && (region == REGION_FIFO);

    vsa16_store_fifo #(
        .FD_LOG2   (FD_LOG2)
    ) u_fifo (
        .clock     (clock),
        .rst       (rst),
        .push      (fifo_push),
        .push_data (wdata),
        .pop_ready (out_ready),
        .valid     (out_valid),
        .head      (out_data),
        .count     (fifo_count),
        .full      (fifo_full),
        .drop      (fifo_drop)
    );

    // NOTE: The RAM must read zero after reset, so it is built from flops and
    // cleared word by word rather than mapped onto an unresettable macro.
    always_ff @(posedge clock) begin
        if (rst) begin
            for (int i = 0; i < WORDS; i++)
                ram[i] <= '0;
        end else if (aligned_wr && (region == REGION_RAM)) begin
            ram[word_idx] <= wdata;
        end
    end

    // A single store either sets one flag or clears both, never both at once.
    always_ff @(posedge clock) begin
        if (rst) begin
            err_misalign <= 1'b0;
            err_overflow <= 1'b0;
        end else if (wr) begin
            if (addr[0]) begin
                err_misalign <= 1'b1;
            end else if (region == REGION_STATUS) begin
                err_misalign <= 1'b0;
                err_overflow <= 1'b0;
            end else if (fifo_drop) begin
                err_overflow <= 1'b1;
            end
        end
    end

    // NOTE: rdata gets a default before the case so every path assigns it
    // and no latch is inferred.
    always_comb begin
        rdata = '0;
        case (region)
            REGION_RAM:    rdata = ram[word_idx];
            REGION_FIFO:   rdata[FD_LOG2:0] = fifo_count;
            REGION_STATUS: begin
                rdata[ST_MISALIGN] = err_misalign;
                rdata[ST_OVERFLOW] = err_overflow;
            end
            default:       rdata = '0;
        endcase
    end

    // Full state is visible through the FIFO_PORT count; kept for clarity.
    logic unused_full;
    assign unused_full = fifo_full;

endmodule

// File: tb/tb_vsa16_dmem.sv
// -----------------------------------------------------------------------------
// tb_vsa16_dmem
// Directed self-checking bench for vsa16_dmem with hand-computed expectations.
// Inputs change and outputs are sampled 1 time unit after the rising edge.
// -----------------------------------------------------------------------------
module tb_vsa16_dmem;

    logic        clock;
    logic        rst;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic        wr;
    logic [15:0] rdata;
    logic        out_valid;
    logic [15:0] out_data;
    logic        out_ready;
    logic        err_misalign;
    logic        err_overflow;

    int checks = 0;
    int errors = 0;

    vsa16_dmem #(
        .AW           (4),
        .FD_LOG2      (2)
    ) dut (
        .clock        (clock),
        .rst          (rst),
        .addr         (addr),
        .wdata        (wdata),
        .wr           (wr),
        .rdata        (rdata),
        .out_valid    (out_valid),
        .out_data     (out_data),
        .out_ready    (out_ready),
        .err_misalign (err_misalign),
        .err_overflow (err_overflow)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string tag, input logic [15:0] got, input logic [15:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic store(input logic [15:0] a, input logic [15:0] d);
        addr  = a;
        wdata = d;
        wr    = 1'b1;
        step();
        wr    = 1'b0;
    endtask

    task automatic load_check(input string tag, input logic [15:0] a, input logic [15:0] exp);
        addr = a;
        #1;
        check(tag, rdata, exp);
    endtask

    logic [15:0] drain_a [4] = '{16'd1, 16'd2, 16'd3, 16'd4};
    logic [15:0] drain_b [4] = '{16'd2, 16'd3, 16'd4, 16'd9};

    initial begin
        rst = 1'b1; wr = 1'b0; addr = '0; wdata = '0; out_ready = 1'b0;
        step();
        step();
        rst = 1'b0;

        // Reset clears RAM, FIFO and flags
        store(16'h0004, 16'h1234);
        load_check("pre_reset_ram", 16'h0004, 16'h1234);
        rst = 1'b1;
        step();
        rst = 1'b0;
        load_check("reset_ram", 16'h0004, 16'h0000);
        check("reset_valid", {15'd0, out_valid}, 16'd0);
        check("reset_misalign", {15'd0, err_misalign}, 16'd0);
        check("reset_overflow", {15'd0, err_overflow}, 16'd0);

        // RAM write/read with alias and ignored bit 0
        store(16'h0006, 16'hBEEF);
        load_check("ram_read", 16'h0006, 16'hBEEF);
        load_check("ram_alias", 16'h0026, 16'hBEEF);
        load_check("ram_odd_load", 16'h0007, 16'hBEEF);

        // Read during write returns the old word; new word next cycle
        addr = 16'h0006; wdata = 16'h1111; wr = 1'b1;
        #1;
        check("rd_during_wr_old", rdata, 16'hBEEF);
        step();
        wr = 1'b0;
        load_check("rd_after_wr_new", 16'h0006, 16'h1111);

        // Unmapped MMIO: loads return 0, stores ignored
        store(16'h8004, 16'h5A5A);
        load_check("mmio_unmapped", 16'h8004, 16'h0000);
        check("mmio_unmapped_noflag", {14'd0, err_overflow, err_misalign}, 16'd0);

        // Misaligned store sets flag and writes nothing
        store(16'h0009, 16'hAAAA);
        check("misalign_flag", {15'd0, err_misalign}, 16'd1);
        load_check("misalign_nowrite", 16'h0008, 16'h0000);
        load_check("status_misalign", 16'h8002, 16'h0001);
        store(16'h8002, 16'hFFFF);
        check("clear_misalign", {15'd0, err_misalign}, 16'd0);
        check("clear_overflow0", {15'd0, err_overflow}, 16'd0);

        // FIFO fill to overflow with consumer stalled
        out_ready = 1'b0;
        for (int i = 1; i <= 5; i++) store(16'h8000, 16'(i));
        load_check("fifo_count_full", 16'h8000, 16'd4);
        check("fifo_overflow", {15'd0, err_overflow}, 16'd1);
        load_check("status_overflow", 16'h8002, 16'h0002);
        out_ready = 1'b1;
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_a_valid%0d", i), {15'd0, out_valid}, 16'd1);
            check($sformatf("drain_a_data%0d", i), out_data, drain_a[i]);
            step();
        end
        check("drain_a_empty", {15'd0, out_valid}, 16'd0);
        load_check("drain_a_count", 16'h8000, 16'd0);
        out_ready = 1'b0;
        store(16'h8002, 16'h0000);
        check("clear_overflow", {15'd0, err_overflow}, 16'd0);

        // Full FIFO: simultaneous push and pop succeeds
        for (int i = 1; i <= 4; i++) store(16'h8000, 16'(i));
        load_check("full_count", 16'h8000, 16'd4);
        out_ready = 1'b1;
        store(16'h8000, 16'd9);
        load_check("pushpop_count", 16'h8000, 16'd4);
        check("pushpop_no_ovf", {15'd0, err_overflow}, 16'd0);
        for (int i = 0; i < 4; i++) begin
            check($sformatf("drain_b_data%0d", i), out_data, drain_b[i]);
            step();
        end
        check("drain_b_empty", {15'd0, out_valid}, 16'd0);
        out_ready = 1'b0;

        // Reset mid-drain empties the FIFO
        for (int i = 7; i <= 9; i++) store(16'h8000, 16'(i));
        load_check("mid_count", 16'h8000, 16'd3);
        out_ready = 1'b1;
        rst = 1'b1;
        step();
        rst = 1'b0;
        check("rst_drain_valid", {15'd0, out_valid}, 16'd0);
        load_check("rst_drain_count", 16'h8000, 16'd0);
        step();
        check("rst_drain_stays_empty", {15'd0, out_valid}, 16'd0);
        out_ready = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
